// File: rtl/parity_pkg.sv
// Shared parity helpers for the parity FIFO slice.
package parity_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Callers zero-extend narrower words; the padding does not change the parity.
  function automatic logic parity_of(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_gen.sv
// Combinational parity generator: p = (^data) XOR odd.
module parity_gen
  import parity_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic [width-1:0] data,
  input  logic             odd,
  output logic             p
);

  logic [63:0] data_ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_ext              = '0;
    data_ext[width-1:0]   = data;
  end

  assign p = parity_of(data_ext, odd);

endmodule

// File: rtl/parity_fifo.sv
// Synchronous FIFO storing one parity bit per word and checking it on read.
// Optional error injection port inj_err when PARITY_FIFO_ERR_INJECT_EN is defined.
module parity_fifo
  import parity_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
`ifdef PARITY_FIFO_ERR_INJECT_EN
  input  logic                     inj_err,
`endif
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     par_err,
  output logic                     err_sticky,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_drop
);

  localparam int   AW  = $clog2(DEPTH);
  localparam int   CW  = AW + 1;
  localparam logic ODD = (ODD_PARITY != 0);

  logic [WIDTH:0]     mem_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               par_err_q, par_err_d;
  logic               err_sticky_q, err_sticky_d;
  logic               wr_drop_q, wr_drop_d;

  logic               wr_ok, rd_ok;
  logic               wr_par, wr_par_stored, rd_par_calc;
  logic [WIDTH:0]     rd_entry;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign rd_entry = mem_q[rd_ptr_q];

  parity_gen #(.width(WIDTH)) u_wr_par (
    .data (wr_data),
    .odd  (ODD),
    .p    (wr_par)
  );

  parity_gen #(.width(WIDTH)) u_rd_par (
    .data (rd_entry[WIDTH-1:0]),
    .odd  (ODD),
    .p    (rd_par_calc)
  );

`ifdef PARITY_FIFO_ERR_INJECT_EN
  assign wr_par_stored = wr_par ^ inj_err;
`else
  assign wr_par_stored = wr_par;
`endif

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_ok;
    par_err_d    = 1'b0;
    wr_drop_d    = wr_en & full;
    // Set dominates clear when a flagged read and clr_err coincide.
    err_sticky_d = (rd_valid_q & par_err_q) | (err_sticky_q & ~clr_err);

    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = rd_entry[WIDTH-1:0];
      par_err_d = rd_par_calc ^ rd_entry[WIDTH];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      par_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      par_err_q    <= par_err_d;
      err_sticky_q <= err_sticky_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= {wr_par_stored, wr_data};
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign par_err    = par_err_q;
  assign err_sticky = err_sticky_q;
  assign count      = count_q;
  assign wr_drop    = wr_drop_q;

endmodule
